// File: rtl/end_game_frame_tx.sv
// End-of-game frame reporter: on trigger, requests a payload build, then sends event/result/score bytes to the UART.
// Define END_GAME_CHECKSUM_EN to append an XOR checksum byte after the score.
module end_game_frame_tx #(
  parameter logic [7:0]  EVENT_CODE    = 8'hAE,
  parameter logic [7:0]  TRIGGER_CODE  = 8'hAB,
  parameter int          SCORE_W       = 5,
  parameter int          SCORE_BYTES   = 1,
  parameter int unsigned WIN_THRESHOLD = 20,
  parameter logic [7:0]  WIN_CODE      = 8'h10,
  parameter logic [7:0]  LOSE_CODE     = 8'h00,
  parameter int          BUILD_TIMEOUT = 1023
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               data_valid,
  input  logic               block,
  input  logic [7:0]         evento,
  input  logic [SCORE_W-1:0] pontuacao,
  input  logic               payload_ready,
  input  logic               tx_busy,
  input  logic               data_sent,
  output logic [7:0]         tx_data,
  output logic               send,
  output logic               build_payload,
  output logic               fim_jogo,
  output logic               vitoria,
  output logic               timeout_err,
  output logic               busy
);

  localparam int SCORE_PAD = 8 * SCORE_BYTES;
  localparam int TIMER_W   = (BUILD_TIMEOUT > 1) ? $clog2(BUILD_TIMEOUT + 1) : 1;
`ifdef END_GAME_CHECKSUM_EN
  localparam int FRAME_LEN = SCORE_BYTES + 3;
`else
  localparam int FRAME_LEN = SCORE_BYTES + 2;
`endif
  localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_BUILD = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_WACK  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]           r_state;
  logic [2:0]           r_index;
  logic [TIMER_W-1:0]   r_timer;
  logic [SCORE_PAD-1:0] r_score;
  logic                 r_win;
`ifdef END_GAME_CHECKSUM_EN
  logic [7:0]           r_csum;
`endif

  logic       w_trigger;
  logic [7:0] w_byte;

  assign w_trigger = data_valid && !block && (evento == TRIGGER_CODE);
  assign busy      = (r_state != S_IDLE);

  // Byte selected by the frame index; score bytes go out most significant first.
  always_comb begin
    w_byte = EVENT_CODE;
    if (r_index == 3'd1) begin
      w_byte = r_win ? WIN_CODE : LOSE_CODE;
    end
    for (int k = 0; k < SCORE_BYTES; k++) begin
      if (r_index == 3'(k + 2)) begin
        w_byte = r_score[8*(SCORE_BYTES-1-k) +: 8];
      end
    end
`ifdef END_GAME_CHECKSUM_EN
    if (r_index == LAST_IDX) begin
      w_byte = r_csum;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_index       <= '0;
      r_timer       <= '0;
      r_score       <= '0;
      r_win         <= 1'b0;
      tx_data       <= '0;
      send          <= 1'b0;
      build_payload <= 1'b0;
      fim_jogo      <= 1'b0;
      vitoria       <= 1'b0;
      timeout_err   <= 1'b0;
`ifdef END_GAME_CHECKSUM_EN
      r_csum        <= '0;
`endif
    end else begin
      send        <= 1'b0;
      fim_jogo    <= 1'b0;
      timeout_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_trigger) begin
            r_state       <= S_BUILD;
            build_payload <= 1'b1;
            r_timer       <= '0;
          end
        end
        S_BUILD: begin
          // Score and result are frozen here so the frame in flight stays consistent.
          if (payload_ready) begin
            r_score       <= SCORE_PAD'(pontuacao);
            r_win         <= (32'(pontuacao) >= WIN_THRESHOLD);
            r_index       <= '0;
            build_payload <= 1'b0;
            r_state       <= S_LOAD;
`ifdef END_GAME_CHECKSUM_EN
            r_csum        <= '0;
`endif
          end else if (r_timer == TIMER_W'(BUILD_TIMEOUT - 1)) begin
            timeout_err   <= 1'b1;
            build_payload <= 1'b0;
            r_state       <= S_IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_LOAD: begin
          if (!tx_busy) begin
            tx_data <= w_byte;
            send    <= 1'b1;
            r_state <= S_WACK;
`ifdef END_GAME_CHECKSUM_EN
            r_csum  <= r_csum ^ w_byte;
`endif
          end
        end
        S_WACK: begin
          if (data_sent) begin
            if (r_index == LAST_IDX) begin
              r_state <= S_DONE;
            end else begin
              r_index <= r_index + 1'b1;
              r_state <= S_LOAD;
            end
          end
        end
        S_DONE: begin
          fim_jogo <= 1'b1;
          vitoria  <= r_win;
          r_state  <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_end_game_frame_tx.sv
// Self-checking bench for end_game_frame_tx: instance A uses defaults, instance B a 12-bit two-byte score with an 8-cycle build timeout.
module tb_end_game_frame_tx;

`ifdef END_GAME_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif
  localparam int NB_A = 3 + CS;
  localparam int NB_B = 4 + CS;

  logic       clk;
  logic       reset;
  logic       dv  [2];
  logic       blk [2];
  logic       pr  [2];
  logic       tb  [2];
  logic       ds  [2];
  logic [7:0] ev  [2];
  logic [4:0] pA;
  logic [11:0] pB;

  logic [7:0] txd [2];
  logic       snd [2];
  logic       bp  [2];
  logic       fim [2];
  logic       vit [2];
  logic       toe [2];
  logic       bsy [2];

  int compareCount = 0;
  int failCount    = 0;
  int sendCnt [2]  = '{0, 0};
  int fimCnt  [2]  = '{0, 0};
  int toeCnt  [2]  = '{0, 0};
  logic expVit [2] = '{1'b0, 1'b0};
  logic [7:0] expQ0 [$];
  logic [7:0] expQ1 [$];
  logic [7:0] popped;

  end_game_frame_tx #(.BUILD_TIMEOUT(1023)) dutA (
    .clk(clk), .reset(reset), .data_valid(dv[0]), .block(blk[0]), .evento(ev[0]),
    .pontuacao(pA), .payload_ready(pr[0]), .tx_busy(tb[0]), .data_sent(ds[0]),
    .tx_data(txd[0]), .send(snd[0]), .build_payload(bp[0]), .fim_jogo(fim[0]),
    .vitoria(vit[0]), .timeout_err(toe[0]), .busy(bsy[0])
  );

  end_game_frame_tx #(.SCORE_W(12), .SCORE_BYTES(2), .BUILD_TIMEOUT(8)) dutB (
    .clk(clk), .reset(reset), .data_valid(dv[1]), .block(blk[1]), .evento(ev[1]),
    .pontuacao(pB), .payload_ready(pr[1]), .tx_busy(tb[1]), .data_sent(ds[1]),
    .tx_data(txd[1]), .send(snd[1]), .build_payload(bp[1]), .fim_jogo(fim[1]),
    .vitoria(vit[1]), .timeout_err(toe[1]), .busy(bsy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compareCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: every send pops one expected byte; every fim_jogo checks vitoria and a drained queue.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (snd[d] === 1'b1) begin
        sendCnt[d]++;
        if (d == 0) begin
          checkOutput("scoreboard_has_byte_A", 32'(expQ0.size() != 0), 1);
          if (expQ0.size() != 0) begin
            popped = expQ0.pop_front();
            checkOutput("tx_data_A", 32'(txd[0]), 32'(popped));
          end
        end else begin
          checkOutput("scoreboard_has_byte_B", 32'(expQ1.size() != 0), 1);
          if (expQ1.size() != 0) begin
            popped = expQ1.pop_front();
            checkOutput("tx_data_B", 32'(txd[1]), 32'(popped));
          end
        end
      end
      if (fim[d] === 1'b1) begin
        fimCnt[d]++;
        checkOutput(d == 0 ? "vitoria_A" : "vitoria_B", 32'(vit[d]), 32'(expVit[d]));
        checkOutput(d == 0 ? "frame_drained_A" : "frame_drained_B",
                    d == 0 ? expQ0.size() : expQ1.size(), 0);
      end
      if (toe[d] === 1'b1) toeCnt[d]++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic setScore(input int d, input int score);
    if (d == 0) pA = 5'(score);
    else        pB = 12'(score);
  endtask

  // Reference frame: event code, result code, score bytes MSB first, optional XOR checksum.
  task automatic pushFrame(input int d, input int score);
    logic [7:0] fr [$];
    logic [7:0] cs;
    bit win;
    int nsb;
    win = (score >= 20);
    nsb = (d == 0) ? 1 : 2;
    fr.push_back(8'hAE);
    fr.push_back(win ? 8'h10 : 8'h00);
    for (int k = nsb - 1; k >= 0; k--) fr.push_back(8'((score >> (8 * k)) & 255));
    if (CS == 1) begin
      cs = 8'h00;
      foreach (fr[i]) cs = cs ^ fr[i];
      fr.push_back(cs);
    end
    foreach (fr[i]) begin
      if (d == 0) expQ0.push_back(fr[i]);
      else        expQ1.push_back(fr[i]);
    end
    expVit[d] = win;
  endtask

  task automatic applyStimulus(input int d, input logic [7:0] code, input logic blockv);
    dv[d]  = 1'b1;
    ev[d]  = code;
    blk[d] = blockv;
    step(1);
    dv[d]  = 1'b0;
    blk[d] = 1'b0;
  endtask

  task automatic waitSend(input int d);
    int n = 0;
    while (snd[d] !== 1'b1 && n < 200) begin
      step(1);
      n++;
    end
    checkOutput("send_seen", 32'(snd[d]), 1);
  endtask

  task automatic waitFim(input int d);
    int n = 0;
    while (fim[d] !== 1'b1 && n < 20) begin
      step(1);
      n++;
    end
    checkOutput("fim_seen", 32'(fim[d]), 1);
  endtask

  task automatic pulseSent(input int d);
    ds[d] = 1'b1;
    step(1);
    ds[d] = 1'b0;
  endtask

  task automatic ackBytes(input int d, input int n, input int ackDelay);
    for (int b = 0; b < n; b++) begin
      waitSend(d);
      pr[d] = 1'b0;
      if (ackDelay > 0) step(ackDelay);
      pulseSent(d);
    end
    waitFim(d);
    step(1);
  endtask

  task automatic doFrame(input int d, input int readyDelay, input int ackDelay,
                         input int score, input int lateScore);
    int s0, f0, nb;
    nb = (d == 0) ? NB_A : NB_B;
    setScore(d, score);
    pushFrame(d, score);
    s0 = sendCnt[d];
    f0 = fimCnt[d];
    applyStimulus(d, 8'hAB, 1'b0);
    step(readyDelay);
    pr[d] = 1'b1;
    step(1);
    setScore(d, lateScore);
    ackBytes(d, nb, ackDelay);
    checkOutput("send_count", sendCnt[d] - s0, nb);
    checkOutput("fim_count", fimCnt[d] - f0, 1);
  endtask

  initial begin
    int s0, sStart, t0;
    reset = 1'b0;
    pA = '0;
    pB = '0;
    for (int d = 0; d < 2; d++) begin
      dv[d] = 1'b0; blk[d] = 1'b0; pr[d] = 1'b0; tb[d] = 1'b0; ds[d] = 1'b0; ev[d] = 8'h00;
    end
    step(3);
    checkOutput("rst_tx_data", 32'(txd[0]), 0);
    checkOutput("rst_send", 32'(snd[0]), 0);
    checkOutput("rst_build", 32'(bp[0]), 0);
    checkOutput("rst_vitoria", 32'(vit[0]), 0);
    checkOutput("rst_busy", 32'(bsy[0]), 0);
    checkOutput("rst_busy_B", 32'(bsy[1]), 0);
    #2 reset = 1'b1;
    step(2);

    $display("[TB] victory at threshold, payload after 4 cycles");
    sStart = sendCnt[0];
    doFrame(0, 4, 10, 20, 20);

    $display("[TB] defeat below threshold, score changes after latch");
    doFrame(0, 2, 3, 19, 31);

    $display("[TB] backpressure on tx_busy and data_sent");
    setScore(0, 7);
    pushFrame(0, 7);
    sStart = sendCnt[0];
    tb[0] = 1'b1;
    pr[0] = 1'b1;
    applyStimulus(0, 8'hAB, 1'b0);
    step(1);
    s0 = sendCnt[0];
    step(20);
    applyStimulus(0, 8'hAB, 1'b0);
    step(29);
    checkOutput("no_send_while_busy", sendCnt[0] - s0, 0);
    checkOutput("busy_in_load", 32'(bsy[0]), 1);
    tb[0] = 1'b0;
    waitSend(0);
    pr[0] = 1'b0;
    step(1);
    s0 = sendCnt[0];
    step(29);
    checkOutput("no_byte_before_ack", sendCnt[0] - s0, 0);
    pulseSent(0);
    ackBytes(0, NB_A - 1, 3);
    checkOutput("backpressure_sends", sendCnt[0] - sStart, NB_A);

    $display("[TB] build timeout on B");
    pr[1] = 1'b0;
    t0 = toeCnt[1];
    s0 = sendCnt[1];
    applyStimulus(1, 8'hAB, 1'b0);
    step(7);
    checkOutput("timeout_not_early", 32'(toe[1]), 0);
    checkOutput("build_held", 32'(bp[1]), 1);
    step(1);
    checkOutput("timeout_pulse", 32'(toe[1]), 1);
    checkOutput("idle_after_timeout", 32'(bsy[1]), 0);
    checkOutput("build_dropped", 32'(bp[1]), 0);
    step(1);
    checkOutput("timeout_single", 32'(toe[1]), 0);
    checkOutput("timeout_count", toeCnt[1] - t0, 1);
    checkOutput("timeout_no_send", sendCnt[1] - s0, 0);

    $display("[TB] blocked and foreign triggers ignored");
    applyStimulus(0, 8'hAB, 1'b1);
    checkOutput("blocked_idle", 32'(bsy[0]), 0);
    applyStimulus(0, 8'hAC, 1'b0);
    checkOutput("wrong_code_idle", 32'(bsy[0]), 0);

    $display("[TB] minimum trigger-to-send latency");
    setScore(0, 25);
    pushFrame(0, 25);
    pr[0] = 1'b1;
    applyStimulus(0, 8'hAB, 1'b0);
    checkOutput("lat_build", 32'(bp[0]), 1);
    step(1);
    checkOutput("lat_not_yet", 32'(snd[0]), 0);
    step(1);
    checkOutput("lat_send", 32'(snd[0]), 1);
    ackBytes(0, NB_A, 1);

    $display("[TB] wide score frames on B");
    doFrame(1, 3, 2, 12'h2A5, 12'h0FF);
    doFrame(1, 1, 0, 5, 4000);

    $display("[TB] reset mid-frame");
    setScore(0, 31);
    pushFrame(0, 31);
    pr[0] = 1'b1;
    applyStimulus(0, 8'hAB, 1'b0);
    waitSend(0);
    pr[0] = 1'b0;
    pulseSent(0);
    waitSend(0);
    reset = 1'b0;
    #1;
    checkOutput("midrst_send", 32'(snd[0]), 0);
    checkOutput("midrst_tx_data", 32'(txd[0]), 0);
    checkOutput("midrst_busy", 32'(bsy[0]), 0);
    checkOutput("midrst_build", 32'(bp[0]), 0);
    checkOutput("midrst_vitoria_A", 32'(vit[0]), 0);
    checkOutput("midrst_vitoria_B", 32'(vit[1]), 0);
    expQ0.delete();
    expVit[0] = 1'b0;
    expVit[1] = 1'b0;
    #1 reset = 1'b1;
    step(2);
    doFrame(0, 2, 1, 31, 0);

    step(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
